// File: rtl/pong_buzzer_seq_if.sv
// pong_buzzer_seq_if
// Groups the game-side strobes, the mute control and the buzzer-side
// outputs of the pong sound sequencer into one bundle.
//
// Signals:
//   enable      game -> seq   1 = sound on, 0 = mute and abort
//   hit_wall    game -> seq   one-cycle strobe, priority 1
//   hit_paddle  game -> seq   one-cycle strobe, priority 2
//   score       game -> seq   one-cycle strobe, priority 3
//   buzzer_out  seq  -> board square-wave drive
//   busy        seq  -> game  high while any tone or note is playing
//   tone_id     seq  -> game  0 none, 1 wall, 2 paddle, 3 score
//   fsm_state   seq  -> debug sequencer state (0 idle, 1 play, 2 note2)
//
// Handshake: there is no valid/ready pair and no back-pressure. Each strobe
// is a single-cycle request sampled on the rising clock edge; a request is
// either accepted (it starts or preempts a tone) or silently dropped. busy
// and tone_id tell the requester what is currently playing.
interface pong_buzzer_seq_if;
  logic       enable;
  logic       hit_wall;
  logic       hit_paddle;
  logic       score;
  logic       buzzer_out;
  logic       busy;
  logic [1:0] tone_id;
  logic [1:0] fsm_state;

  modport master (
    output enable, hit_wall, hit_paddle, score,
    input  buzzer_out, busy, tone_id, fsm_state
  );

  modport slave (
    input  enable, hit_wall, hit_paddle, score,
    output buzzer_out, busy, tone_id, fsm_state
  );
endinterface

// File: rtl/pong_buzzer_seq.sv
// pong_buzzer_seq
// Event-driven sound sequencer for pong. Each one-cycle game strobe becomes
// a timed square-wave tone on the buzzer. Tones come from dividing clock_in
// with a half-period counter; durations come from a millisecond-style
// prescaler feeding a tick counter. A score plays two notes back to back.
//
// Ports:
//   clock_in  system clock
//   reset     asynchronous, active-high reset
//   bus       pong_buzzer_seq_if.slave (strobes, enable, buzzer, status)
module pong_buzzer_seq #(
  parameter int DIV_WALL    = 100000,
  parameter int DIV_PADDLE  = 50000,
  parameter int DIV_SCORE_A = 62500,
  parameter int DIV_SCORE_B = 31250,
  parameter int MS_DIV      = 50000,
  parameter int DUR_WALL    = 30,
  parameter int DUR_PADDLE  = 60,
  parameter int DUR_SCORE   = 150,
  parameter int CW          = 20
) (
  input  logic              clock_in,
  input  logic              reset,
  pong_buzzer_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_NOTE2 = 2'd2;

  localparam logic [CW-1:0] WALL_M1    = CW'(DIV_WALL - 1);
  localparam logic [CW-1:0] PADDLE_M1  = CW'(DIV_PADDLE - 1);
  localparam logic [CW-1:0] SCORE_A_M1 = CW'(DIV_SCORE_A - 1);
  localparam logic [CW-1:0] SCORE_B_M1 = CW'(DIV_SCORE_B - 1);
  localparam logic [CW-1:0] MS_M1      = CW'(MS_DIV - 1);
  localparam logic [CW-1:0] DUR_W_M1   = CW'(DUR_WALL - 1);
  localparam logic [CW-1:0] DUR_P_M1   = CW'(DUR_PADDLE - 1);
  localparam logic [CW-1:0] DUR_S_M1   = CW'(DUR_SCORE - 1);

  logic [1:0]    state;
  logic [1:0]    tid;
  logic          buzz;
  logic [CW-1:0] half_cnt;
  logic [CW-1:0] pre_cnt;
  logic [CW-1:0] tick_cnt;

  logic [1:0]    req;
  logic          start;
  logic [CW-1:0] div_m1;
  logic [CW-1:0] dur_m1;
  logic          half_wrap;
  logic          pre_wrap;
  logic          note_end;

  // Priority encode the strobes; the encoded value doubles as the tone_id.
  always_comb begin
    req = 2'd0;
    if (bus.score)           req = 2'd3;
    else if (bus.hit_paddle) req = 2'd2;
    else if (bus.hit_wall)   req = 2'd1;
  end

  // tid is 0 while idle, so one strict compare covers both a fresh start
  // and preemption of a lower-priority tone.
  assign start = bus.enable && (req > tid);

  always_comb begin
    div_m1 = WALL_M1;
    dur_m1 = DUR_W_M1;
    case (tid)
      2'd2: begin
        div_m1 = PADDLE_M1;
        dur_m1 = DUR_P_M1;
      end
      2'd3: begin
        div_m1 = (state == S_NOTE2) ? SCORE_B_M1 : SCORE_A_M1;
        dur_m1 = DUR_S_M1;
      end
      default: begin
        div_m1 = WALL_M1;
        dur_m1 = DUR_W_M1;
      end
    endcase
  end

  assign half_wrap = (half_cnt == div_m1);
  assign pre_wrap  = (pre_cnt == MS_M1);
  assign note_end  = pre_wrap && (tick_cnt == dur_m1);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tid      <= 2'd0;
      buzz     <= 1'b0;
      half_cnt <= '0;
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else if (!bus.enable) begin
      state    <= S_IDLE;
      tid      <= 2'd0;
      buzz     <= 1'b0;
      half_cnt <= '0;
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else if (start) begin
      state    <= S_PLAY;
      tid      <= req;
      buzz     <= 1'b0;
      half_cnt <= '0;
      pre_cnt  <= '0;
      tick_cnt <= '0;
    end else if (state != S_IDLE) begin
      if (note_end) begin
        buzz     <= 1'b0;
        half_cnt <= '0;
        pre_cnt  <= '0;
        tick_cnt <= '0;
        // Score note A chains into note B with busy held high.
        if (state == S_PLAY && tid == 2'd3) begin
          state <= S_NOTE2;
        end else begin
          state <= S_IDLE;
          tid   <= 2'd0;
        end
      end else begin
        if (half_wrap) begin
          half_cnt <= '0;
          buzz     <= ~buzz;
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
        if (pre_wrap) begin
          pre_cnt  <= '0;
          tick_cnt <= tick_cnt + 1'b1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  end

  // Mute gates the pin immediately, ahead of the registered abort.
  assign bus.buzzer_out = buzz & bus.enable;
  assign bus.busy       = (state != S_IDLE);
  assign bus.tone_id    = tid;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_pong_buzzer_seq.sv
// tb_pong_buzzer_seq
// Directed bench for pong_buzzer_seq with small dividers. The driver pushes,
// for every cycle it drives, the expected {busy, tone_id, buzzer_out} of
// that cycle; a monitor pops and compares shortly after each rising edge.
module tb_pong_buzzer_seq;

  localparam int DIV_WALL    = 4;
  localparam int DIV_PADDLE  = 5;
  localparam int DIV_SCORE_A = 3;
  localparam int DIV_SCORE_B = 2;
  localparam int MS_DIV      = 10;
  localparam int DUR_WALL    = 3;
  localparam int DUR_PADDLE  = 2;
  localparam int DUR_SCORE   = 2;
  localparam int CW          = 20;

  localparam int LEN_WALL   = DUR_WALL * MS_DIV;    // 30
  localparam int LEN_PADDLE = DUR_PADDLE * MS_DIV;  // 20
  localparam int LEN_SCORE  = DUR_SCORE * MS_DIV;   // 20 per note

  // clock / reset
  logic clock_in;
  logic reset;

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  pong_buzzer_seq_if bus ();

  pong_buzzer_seq #(
    .DIV_WALL   (DIV_WALL),
    .DIV_PADDLE (DIV_PADDLE),
    .DIV_SCORE_A(DIV_SCORE_A),
    .DIV_SCORE_B(DIV_SCORE_B),
    .MS_DIV     (MS_DIV),
    .DUR_WALL   (DUR_WALL),
    .DUR_PADDLE (DUR_PADDLE),
    .DUR_SCORE  (DUR_SCORE),
    .CW         (CW)
  ) dut (
    .clock_in(clock_in),
    .reset   (reset),
    .bus     (bus)
  );

  // parameter legality
  initial begin
    if (DIV_WALL < 2 || DIV_PADDLE < 2 || DIV_SCORE_A < 2 || DIV_SCORE_B < 2 ||
        MS_DIV < 2 || DIV_WALL >= (1 << CW) || DIV_PADDLE >= (1 << CW) ||
        DIV_SCORE_A >= (1 << CW) || DIV_SCORE_B >= (1 << CW) ||
        MS_DIV >= (1 << CW))
      $fatal(1, "[TB] illegal divider parameters");
  end

  // scoreboard
  logic [3:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t {busy,tone_id,buzzer}: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // monitor: the DUT presents its outputs every cycle
  always begin
    @(posedge clock_in);
    #3;
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      chk("cycle", {bus.busy, bus.tone_id, bus.buzzer_out}, e);
    end
  end

  // driver tasks
  task automatic drive(input logic en, input logic w, input logic p, input logic s,
                       input logic [3:0] e);
    @(posedge clock_in);
    #1;
    bus.enable     = en;
    bus.hit_wall   = w;
    bus.hit_paddle = p;
    bus.score      = s;
    exp_q.push_back(e);
  endtask

  function automatic logic wave(input int i, input int div);
    return ((i / div) % 2) == 1;
  endfunction

  // cycles [from, to) of a note: low for div cycles, then period 2*div
  task automatic note(input logic [1:0] tid, input int div, input int from, input int to);
    for (int i = from; i < to; i++)
      drive(1'b1, 1'b0, 1'b0, 1'b0, {1'b1, tid, wave(i, div)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    reset          = 1'b1;
    bus.enable     = 1'b1;
    bus.hit_wall   = 1'b0;
    bus.hit_paddle = 1'b0;
    bus.score      = 1'b0;
    repeat (2) @(posedge clock_in);
    #2;
    chk("reset_outputs", {bus.busy, bus.tone_id, bus.buzzer_out}, 4'b0000);
    chk("reset_state", {2'b00, bus.fsm_state}, 4'b0000);
    reset = 1'b0;
    idle(2);

    // wall tone: 30 cycles, low 4 / high 4 ..., ends with high 2
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    note(2'd1, DIV_WALL, 0, LEN_WALL);
    idle(3);

    // score: 20 cycles period 6, then 20 cycles period 4, no gap
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    note(2'd3, DIV_SCORE_A, 0, LEN_SCORE);
    note(2'd3, DIV_SCORE_B, 0, LEN_SCORE);
    idle(3);

    // simultaneous wall + paddle: paddle wins
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    note(2'd2, DIV_PADDLE, 0, LEN_PADDLE);
    idle(2);

    // wall during paddle: ignored, duration unchanged
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    note(2'd2, DIV_PADDLE, 0, 5);
    drive(1'b1, 1'b1, 1'b0, 1'b0, {1'b1, 2'd2, wave(5, DIV_PADDLE)});
    note(2'd2, DIV_PADDLE, 6, LEN_PADDLE);
    idle(2);

    // score at cycle 7 of paddle: preempts and restarts from zero
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    note(2'd2, DIV_PADDLE, 0, 7);
    drive(1'b1, 1'b0, 1'b0, 1'b1, {1'b1, 2'd2, wave(7, DIV_PADDLE)});
    note(2'd3, DIV_SCORE_A, 0, LEN_SCORE);
    note(2'd3, DIV_SCORE_B, 0, LEN_SCORE);
    idle(2);

    // mute mid-tone: pin low at once, busy drops next cycle
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    note(2'd1, DIV_WALL, 0, 6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, {1'b1, 2'd1, 1'b0});
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    idle(3);

    // asynchronous reset during score note B
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    note(2'd3, DIV_SCORE_A, 0, LEN_SCORE);
    note(2'd3, DIV_SCORE_B, 0, 5);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", {bus.busy, bus.tone_id, bus.buzzer_out}, 4'b0000);
    chk("async_reset_state", {2'b00, bus.fsm_state}, 4'b0000);
    @(posedge clock_in);
    #1;
    reset          = 1'b0;
    bus.enable     = 1'b1;
    bus.hit_wall   = 1'b0;
    bus.hit_paddle = 1'b1;
    bus.score      = 1'b0;
    exp_q.push_back(4'b0000);
    note(2'd2, DIV_PADDLE, 0, LEN_PADDLE);
    idle(3);

    // wall strobe in last cycle of a wall tone: ignored
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    note(2'd1, DIV_WALL, 0, LEN_WALL - 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, {1'b1, 2'd1, wave(LEN_WALL - 1, DIV_WALL)});
    idle(4);

    // drain
    repeat (2) @(posedge clock_in);
    #4;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
